// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
//   Groups the requester-side and RAM-side signals of the bus arbiter.
//   Requester side: iREN/iaddr (instruction fetch), dREN/dWEN/daddr/dstore
//     (data access), with iwait/dwait and iload/dload coming back.
//   RAM side: ramaddr/ramstore/ramREN/ramWEN towards the RAM,
//     ramload/ramstate (FREE=0, BUSY=1, ACCESS=2, ERROR=3) coming back.
//   gnt reports the current owner (0 none, 1 instruction, 2 data).
//   Modports:
//     slave  - the arbiter's view
//     master - the view of whatever surrounds the arbiter (CPU + RAM)
interface bus_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [1:0]  gnt;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, gnt
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, gnt
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one RAM port between an instruction-fetch requester and a data
//   requester. Data normally wins a simultaneous request; once an
//   instruction fetch has lost arbitration STARVE_MAX times in a row it is
//   granted next, so fetches cannot be starved by a stream of data accesses.
//   Ports:
//     CLK  - clock, all state changes on the rising edge
//     nRST - asynchronous reset, active high (despite the name)
//     bus  - bus_arbiter_if.slave carrying requests, RAM signals and gnt
//   Parameters:
//     STARVE_MAX - lost arbitrations before a fetch is forced through (1..7)
module bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  bus_arbiter_if.slave    bus
);

  localparam logic [1:0] RAM_ACCESS   = 2'd2;
  localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] starve_cnt;
  logic [2:0] starve_next;
  logic       d_req;
  logic       access;

  assign d_req  = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == RAM_ACCESS);

  // Arbitration and starvation tracking. A "lost arbitration" is an IDLE
  // cycle in which a fetch was pending but the grant went elsewhere; cycles
  // spent waiting while data owns the bus are not counted, which gives the
  // D,D,D,D,I rotation for STARVE_MAX=4 under continuous contention.
  always_comb begin
    next_state  = state;
    starve_next = starve_cnt;
    case (state)
      IDLE: begin
        if (d_req && (!bus.iREN || starve_cnt < STARVE_LIMIT)) begin
          next_state = SERVE_D;
        end else if (bus.iREN) begin
          next_state = SERVE_I;
        end
        if (bus.iREN && next_state != SERVE_I && starve_cnt < STARVE_LIMIT) begin
          starve_next = starve_cnt + 3'd1;
        end
      end
      SERVE_I: begin
        // Dropping the request abandons the access without completion.
        if (!bus.iREN || access) begin
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        if (!d_req || access) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (next_state == SERVE_I && state != SERVE_I) begin
      starve_next = 3'd0;
    end
  end

  // Reset is asynchronous so the RAM enables, decoded from state, drop the
  // instant nRST rises even in the middle of a transaction.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_next;
    end
  end

  // RAM-side drive. Enables depend only on state and request inputs, never
  // on ramstate, so an ERROR simply keeps the same request on the bus.
  // A write wins when dREN and dWEN are both raised.
  always_comb begin
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    case (state)
      SERVE_I: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
      end
      SERVE_D: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
      end
      default: ;
    endcase
  end

  assign bus.gnt   = state;
  assign bus.iwait = bus.iREN & ~((state == SERVE_I) & access);
  assign bus.dwait = d_req & ~((state == SERVE_D) & access);
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed bench for bus_arbiter (STARVE_MAX=4). Stimulus pushes the
//   expected completion records into a scoreboard queue; a monitor on the
//   falling edge pops one whenever a requester sees its wait drop, and
//   compares owner, RAM drive and returned data. Cycle-level behaviour
//   (grant latency, reset abort, dropped requests) is checked inline.
module tb_bus_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  logic   CLK;
  logic   nRST;
  int     checks;
  int     errors;
  exp_t   sb[$];

  bus_arbiter_if bus();

  bus_arbiter #(.STARVE_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iren, input logic [31:0] iaddr,
                               input logic dren, input logic dwen,
                               input logic [31:0] daddr, input logic [31:0] dstore,
                               input logic [1:0] rstate, input logic [31:0] rload);
    bus.iREN     = iren;
    bus.iaddr    = iaddr;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.daddr    = daddr;
    bus.dstore   = dstore;
    bus.ramstate = rstate;
    bus.ramload  = rload;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [31:0] a, input logic r,
                          input logic w, input logic [31:0] s, input logic [31:0] l);
    exp_t e;
    e.gnt = g; e.addr = a; e.ren = r; e.wen = w; e.store = s; e.load = l;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    next_cycle();
    next_cycle();
    nRST = 1'b0;
  endtask

  // Completion monitor: a requester whose request is up but whose wait is
  // down has just finished; match it against the oldest expected record.
  always @(negedge CLK) begin
    if ((bus.iREN && !bus.iwait) || ((bus.dREN || bus.dWEN) && !bus.dwait)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_completion", {30'd0, bus.gnt}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("cmp_gnt",      {30'd0, bus.gnt}, {30'd0, e.gnt});
        checkOutput("cmp_ramaddr",  bus.ramaddr,      e.addr);
        checkOutput("cmp_ramREN",   {31'd0, bus.ramREN}, {31'd0, e.ren});
        checkOutput("cmp_ramWEN",   {31'd0, bus.ramWEN}, {31'd0, e.wen});
        checkOutput("cmp_ramstore", bus.ramstore,     e.store);
        if (e.gnt == 2'd1) begin
          checkOutput("cmp_iload", bus.iload, e.load);
          checkOutput("cmp_iwait_owner_only", {31'd0, bus.dwait},
                      {31'd0, bus.dREN | bus.dWEN});
        end else begin
          checkOutput("cmp_dload", bus.dload, e.load);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b1;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, FREE, 0);
    #2;
    // Reset state: idle, nothing driven, iwait follows the raw request.
    checkOutput("rst_gnt",      {30'd0, bus.gnt}, 32'd0);
    checkOutput("rst_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    checkOutput("rst_ramWEN",   {31'd0, bus.ramWEN}, 32'd0);
    checkOutput("rst_ramaddr",  bus.ramaddr, 32'd0);
    checkOutput("rst_iwait",    {31'd0, bus.iwait}, 32'd1);
    checkOutput("rst_dwait",    {31'd0, bus.dwait}, 32'd0);
    next_cycle();
    checkOutput("rst_hold_gnt", {30'd0, bus.gnt}, 32'd0);
    do_reset();

    // Single fetch, two BUSY cycles then ACCESS.
    next_cycle();
    applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
    #2;
    checkOutput("f_c0_gnt",   {30'd0, bus.gnt}, 32'd0);
    checkOutput("f_c0_iwait", {31'd0, bus.iwait}, 32'd1);
    next_cycle();
    #2;
    checkOutput("f_c1_gnt",     {30'd0, bus.gnt}, 32'd1);
    checkOutput("f_c1_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    checkOutput("f_c1_ramaddr", bus.ramaddr, 32'h40);
    checkOutput("f_c1_iwait",   {31'd0, bus.iwait}, 32'd1);
    next_cycle();
    #2;
    checkOutput("f_c2_iwait",   {31'd0, bus.iwait}, 32'd1);
    next_cycle();
    push_exp(2'd1, 32'h40, 1'b1, 1'b0, 32'd0, 32'hDEADBEEF);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEADBEEF);
    #2;
    checkOutput("f_c3_iwait", {31'd0, bus.iwait}, 32'd0);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    #2;
    checkOutput("f_c4_gnt",    {30'd0, bus.gnt}, 32'd0);
    checkOutput("f_c4_ramREN", {31'd0, bus.ramREN}, 32'd0);

    // Data write with dREN also raised: the write must win.
    next_cycle();
    applyStimulus(0, 0, 1, 1, 32'h80, 32'h1234, FREE, 0);
    #2;
    checkOutput("w_c0_dwait", {31'd0, bus.dwait}, 32'd1);
    next_cycle();
    applyStimulus(0, 0, 1, 1, 32'h80, 32'h1234, BUSY, 0);
    #2;
    checkOutput("w_c1_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
    checkOutput("w_c1_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    checkOutput("w_c1_ramaddr",  bus.ramaddr, 32'h80);
    checkOutput("w_c1_ramstore", bus.ramstore, 32'h1234);
    checkOutput("w_c1_dwait",    {31'd0, bus.dwait}, 32'd1);
    next_cycle();
    push_exp(2'd2, 32'h80, 1'b0, 1'b1, 32'h1234, 32'hA5A5A5A5);
    applyStimulus(0, 0, 1, 1, 32'h80, 32'h1234, ACCESS, 32'hA5A5A5A5);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    #2;
    checkOutput("w_c3_gnt",   {30'd0, bus.gnt}, 32'd0);
    checkOutput("w_c3_dwait", {31'd0, bus.dwait}, 32'd0);

    // Continuous contention, single-cycle accesses: D,D,D,D,I twice.
    do_reset();
    next_cycle();
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 32'h55, ACCESS, 32'h11112222);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_exp(2'd2, 32'h200, 1'b1, 1'b0, 32'h55, 32'h11112222);
      push_exp(2'd1, 32'h100, 1'b1, 1'b0, 32'd0, 32'h11112222);
    end
    repeat (20) next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    next_cycle();
    checkOutput("starve_seq_drained", sb.size(), 32'd0);

    // Data read hit by three ERRORs: request stays up, one completion.
    next_cycle();
    applyStimulus(0, 0, 1, 0, 32'h300, 0, FREE, 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      applyStimulus(0, 0, 1, 0, 32'h300, 0, ERROR, 0);
      #2;
      checkOutput("err_ramREN", {31'd0, bus.ramREN}, 32'd1);
      checkOutput("err_dwait",  {31'd0, bus.dwait}, 32'd1);
      checkOutput("err_gnt",    {30'd0, bus.gnt}, 32'd2);
    end
    next_cycle();
    push_exp(2'd2, 32'h300, 1'b1, 1'b0, 32'd0, 32'hCAFEF00D);
    applyStimulus(0, 0, 1, 0, 32'h300, 0, ACCESS, 32'hCAFEF00D);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    #2;
    checkOutput("err_done_gnt", {30'd0, bus.gnt}, 32'd0);
    checkOutput("err_drained",  sb.size(), 32'd0);

    // Reset mid-fetch: enables drop at once, fetch restarts afterwards.
    next_cycle();
    applyStimulus(1, 32'h44, 0, 0, 0, 0, BUSY, 0);
    next_cycle();
    #2;
    checkOutput("ra_c1_ramREN", {31'd0, bus.ramREN}, 32'd1);
    next_cycle();
    #2;
    nRST = 1'b1;
    #1;
    checkOutput("ra_ramREN_async", {31'd0, bus.ramREN}, 32'd0);
    checkOutput("ra_gnt_async",    {30'd0, bus.gnt}, 32'd0);
    checkOutput("ra_iwait",        {31'd0, bus.iwait}, 32'd1);
    next_cycle();
    nRST = 1'b0;
    #2;
    checkOutput("ra_release_gnt", {30'd0, bus.gnt}, 32'd0);
    next_cycle();
    push_exp(2'd1, 32'h44, 1'b1, 1'b0, 32'd0, 32'h0BADF00D);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'h0BADF00D);
    #2;
    checkOutput("ra_regrant_gnt", {30'd0, bus.gnt}, 32'd1);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);

    // Fetch withdrawn before ACCESS, pending data granted right after.
    next_cycle();
    applyStimulus(1, 32'h48, 0, 0, 0, 0, BUSY, 0);
    next_cycle();
    applyStimulus(1, 32'h48, 1, 0, 32'h500, 0, BUSY, 0);
    #2;
    checkOutput("dr_c1_gnt", {30'd0, bus.gnt}, 32'd1);
    next_cycle();
    applyStimulus(0, 32'h48, 1, 0, 32'h500, 0, BUSY, 0);
    next_cycle();
    #2;
    checkOutput("dr_c3_gnt",    {30'd0, bus.gnt}, 32'd0);
    checkOutput("dr_c3_ramREN", {31'd0, bus.ramREN}, 32'd0);
    checkOutput("dr_c3_iwait",  {31'd0, bus.iwait}, 32'd0);
    checkOutput("dr_c3_dwait",  {31'd0, bus.dwait}, 32'd1);
    next_cycle();
    push_exp(2'd2, 32'h500, 1'b1, 1'b0, 32'd0, 32'h600DCAFE);
    applyStimulus(0, 0, 1, 0, 32'h500, 0, ACCESS, 32'h600DCAFE);
    #2;
    checkOutput("dr_c4_gnt", {30'd0, bus.gnt}, 32'd2);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    next_cycle();
    next_cycle();
    checkOutput("final_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
